// File: rtl/parity_frame_rx_pkg.sv
// Shared types and constants for the serial parity frame receiver.
// Optional build macro PARITY_FRAME_RX_DROP_EN is consumed by the top module.
package parity_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Bit counter must be able to hold the value DATA_W.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial-in / byte-out bundle for parity_frame_rx; master drives the link, slave is the receiver.
interface parity_frame_rx_if #(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 bit_valid;
    logic                 rx_bit;
    logic                 frame_start;
    logic                 clear_cnt;
    logic [DATA_W-1:0]    data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_abort;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 busy;

    modport master (
        output bit_valid, rx_bit, frame_start, clear_cnt,
        input  data_out, data_valid, parity_err, frame_abort, err_cnt, busy
    );

    modport slave (
        input  bit_valid, rx_bit, frame_start, clear_cnt,
        output data_out, data_valid, parity_err, frame_abort, err_cnt, busy
    );
endinterface

// File: rtl/parity_frame_rx_reduce.sv
// Combinational XOR reduction, shared with the transmit-side parity generator.
module parity_reduce #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);
    assign parity_o = ^data_i;
endmodule

// File: rtl/parity_frame_rx.sv
// Deserializes LSB-first frames plus one parity bit; data_valid one cycle after the parity bit.
// Build with PARITY_FRAME_RX_DROP_EN to suppress delivery of frames that fail parity.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int ERR_CNT_W  = 8
) (
    input logic              clk,
    input logic              reset,
    parity_frame_rx_if.slave bus
);
    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic PARITY_EXP = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_abort_q, frame_abort_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 data_par;
    logic                 frame_err;
    logic                 err_inc;

    parity_reduce #(.DATA_W(DATA_W)) u_par (
        .data_i   (shift_q),
        .parity_o (data_par)
    );

    // Only meaningful while the current bit is the parity bit.
    assign frame_err = ((data_par ^ bus.rx_bit) != PARITY_EXP);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        data_out_d    = data_out_q;
        parity_err_d  = parity_err_q;
        data_valid_d  = 1'b0;
        frame_abort_d = 1'b0;
        err_inc       = 1'b0;

        if (bus.bit_valid) begin
            if (bus.frame_start) begin
                // A start always opens a new frame; any partial one is dropped.
                frame_abort_d = (state_q != IDLE);
                shift_d       = DATA_W'(bus.rx_bit);
                cnt_d         = CNT_W'(1);
                state_d       = DATA;
            end else begin
                case (state_q)
                    IDLE: ;
                    DATA: begin
                        shift_d = shift_q | (DATA_W'(bus.rx_bit) << cnt_q);
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        err_inc = frame_err;
`ifdef PARITY_FRAME_RX_DROP_EN
                        if (!frame_err) begin
                            data_valid_d = 1'b1;
                            data_out_d   = shift_q;
                            parity_err_d = 1'b0;
                        end
`else
                        data_valid_d = 1'b1;
                        data_out_d   = shift_q;
                        parity_err_d = frame_err;
`endif
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (bus.clear_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.busy        = (state_q == DATA) || (state_q == PARITY);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Drives three receivers in lockstep (even/8-bit count, odd/8-bit count, even/2-bit count)
// and checks them against a frame-level model built from queues and bit counts.
module tb_parity_frame_rx;

`ifdef PARITY_FRAME_RX_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bv = 1'b0, rb = 1'b0, fs = 1'b0, clr = 1'b0;

    always #5 clk = ~clk;

    parity_frame_rx_if #(.DATA_W(8), .ERR_CNT_W(8)) b0 ();
    parity_frame_rx_if #(.DATA_W(8), .ERR_CNT_W(8)) b1 ();
    parity_frame_rx_if #(.DATA_W(8), .ERR_CNT_W(2)) b2 ();

    assign b0.bit_valid = bv; assign b0.rx_bit = rb; assign b0.frame_start = fs; assign b0.clear_cnt = clr;
    assign b1.bit_valid = bv; assign b1.rx_bit = rb; assign b1.frame_start = fs; assign b1.clear_cnt = clr;
    assign b2.bit_valid = bv; assign b2.rx_bit = rb; assign b2.frame_start = fs; assign b2.clear_cnt = clr;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0), .ERR_CNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(b0));
    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1), .ERR_CNT_W(8)) u1 (.clk(clk), .reset(reset), .bus(b1));
    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0), .ERR_CNT_W(2)) u2 (.clk(clk), .reset(reset), .bus(b2));

    logic [7:0] o_dout [3];
    logic [7:0] o_cnt  [3];
    logic       o_dv   [3];
    logic       o_perr [3];
    logic       o_ab   [3];
    logic       o_busy [3];

    assign o_dout[0] = b0.data_out;  assign o_dout[1] = b1.data_out;  assign o_dout[2] = b2.data_out;
    assign o_cnt[0]  = b0.err_cnt;   assign o_cnt[1]  = b1.err_cnt;   assign o_cnt[2]  = {6'b0, b2.err_cnt};
    assign o_dv[0]   = b0.data_valid; assign o_dv[1] = b1.data_valid; assign o_dv[2] = b2.data_valid;
    assign o_perr[0] = b0.parity_err; assign o_perr[1] = b1.parity_err; assign o_perr[2] = b2.parity_err;
    assign o_ab[0]   = b0.frame_abort; assign o_ab[1] = b1.frame_abort; assign o_ab[2] = b2.frame_abort;
    assign o_busy[0] = b0.busy;      assign o_busy[1] = b1.busy;      assign o_busy[2] = b2.busy;

    // Reference model state
    bit         m_bits [$];
    bit         m_in;
    logic [7:0] m_dout [3];
    logic       m_perr [3];
    logic       m_dv   [3];
    logic       m_ab;
    int         m_cnt  [3];
    int         exp_dv [3], obs_dv [3], obs_ab [3], busy_bad [3];
    int         exp_ab;

    int n_vec = 0;
    int n_err = 0;

    function automatic int cnt_max(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_in = 1'b0;
        m_ab = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_dout[i] = 8'h00; m_perr[i] = 1'b0; m_dv[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    // One clock: apply inputs, advance the model, tally observed pulses.
    task automatic cycle(input logic v, input logic b, input logic f, input logic c);
        logic [7:0] w;
        int         ones;
        logic       pe;
        logic       inc [3];
        bv = v; rb = b; fs = f; clr = c;
        @(posedge clk);
        #1;
        m_ab = 1'b0;
        for (int i = 0; i < 3; i++) begin m_dv[i] = 1'b0; inc[i] = 1'b0; end
        if (v) begin
            if (f) begin
                m_ab = m_in;
                m_bits.delete();
                m_bits.push_back(b);
                m_in = 1'b1;
            end else if (m_in) begin
                if (m_bits.size() < 8) begin
                    m_bits.push_back(b);
                end else begin
                    w = 8'h00;
                    for (int k = 0; k < 8; k++) w = w + (8'(m_bits[k]) << k);
                    ones = $countones(w) + int'(b);
                    m_in = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        pe = ((ones % 2) == 1) != (i == 1);
                        inc[i] = pe;
                        if (!(DROP && pe)) begin
                            m_dv[i] = 1'b1; m_dout[i] = w; m_perr[i] = pe; exp_dv[i]++;
                        end
                    end
                end
            end
        end
        if (m_ab) exp_ab++;
        for (int i = 0; i < 3; i++) begin
            if (c) m_cnt[i] = 0;
            else if (inc[i] && m_cnt[i] < cnt_max(i)) m_cnt[i]++;
            if (o_dv[i] === 1'b1) obs_dv[i]++;
            if (o_ab[i] === 1'b1) obs_ab[i]++;
            if (o_busy[i] !== m_in) busy_bad[i]++;
        end
    endtask

    // Sends bits first..last of a frame (index 8 is the parity bit) with random idle gaps.
    task automatic send_frame(input logic [7:0] w, input logic p, input int maxgap,
                              input logic clr_last, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            int g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) cycle(1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0);
            cycle(1'b1, (k < 8) ? w[k] : p, (k == 0), clr_last && (k == 8));
        end
    endtask

    task automatic do_reset();
        bv = 1'b0; fs = 1'b0; clr = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (o_dout[i] !== 8'h00) begin n_err++; $display("FAIL reset_dout[%0d] got=%h want=00", i, o_dout[i]); end
            n_vec++; if (o_dv[i] !== 1'b0) begin n_err++; $display("FAIL reset_dv[%0d] got=%b want=0", i, o_dv[i]); end
            n_vec++; if (o_perr[i] !== 1'b0) begin n_err++; $display("FAIL reset_perr[%0d] got=%b want=0", i, o_perr[i]); end
            n_vec++; if (o_ab[i] !== 1'b0) begin n_err++; $display("FAIL reset_abort[%0d] got=%b want=0", i, o_ab[i]); end
            n_vec++; if (o_cnt[i] !== 8'h00) begin n_err++; $display("FAIL reset_cnt[%0d] got=%0d want=0", i, o_cnt[i]); end
            n_vec++; if (o_busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got=%b want=0", i, o_busy[i]); end
        end
    endtask

    task automatic test_even_good();
        send_frame(8'hA5, 1'b0, 0, 1'b0, 0, 8);
        n_vec++; if (o_dv[0] !== 1'b1) begin n_err++; $display("FAIL even_dv got=%b want=1", o_dv[0]); end
        n_vec++; if (o_dout[0] !== 8'hA5) begin n_err++; $display("FAIL even_dout got=%h want=a5", o_dout[0]); end
        n_vec++; if (o_perr[0] !== 1'b0) begin n_err++; $display("FAIL even_perr got=%b want=0", o_perr[0]); end
        n_vec++; if (o_cnt[0] !== 8'd0) begin n_err++; $display("FAIL even_cnt got=%0d want=0", o_cnt[0]); end
        n_vec++; if (o_dv[1] !== m_dv[1] || o_perr[1] !== m_perr[1]) begin
            n_err++; $display("FAIL odd_on_a5 got dv=%b perr=%b want dv=%b perr=%b", o_dv[1], o_perr[1], m_dv[1], m_perr[1]); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (o_dv[0] !== 1'b0) begin n_err++; $display("FAIL even_dv_pulse got=%b want=0", o_dv[0]); end
        n_vec++; if (o_dout[0] !== 8'hA5) begin n_err++; $display("FAIL even_dout_hold got=%h want=a5", o_dout[0]); end
    endtask

    task automatic test_bad_parity();
        send_frame(8'hA5, 1'b1, 0, 1'b0, 0, 8);
        n_vec++; if (o_cnt[0] !== 8'd1) begin n_err++; $display("FAIL bad_cnt got=%0d want=1", o_cnt[0]); end
        n_vec++; if (o_dv[0] !== m_dv[0] || o_perr[0] !== m_perr[0]) begin
            n_err++; $display("FAIL bad_flags got dv=%b perr=%b want dv=%b perr=%b", o_dv[0], o_perr[0], m_dv[0], m_perr[0]); end
        send_frame(8'h07, 1'b0, 0, 1'b0, 0, 8);
        n_vec++; if (o_dv[1] !== 1'b1 || o_perr[1] !== 1'b0 || o_dout[1] !== 8'h07) begin
            n_err++; $display("FAIL odd_07 got dv=%b perr=%b dout=%h want dv=1 perr=0 dout=07", o_dv[1], o_perr[1], o_dout[1]); end
        n_vec++; if (o_cnt[0] !== 8'd2) begin n_err++; $display("FAIL even_07_cnt got=%0d want=2", o_cnt[0]); end
    endtask

    task automatic test_gaps();
        send_frame(8'h3C, 1'b0, 5, 1'b0, 0, 8);
        n_vec++; if (o_dv[0] !== 1'b1 || o_dout[0] !== 8'h3C || o_perr[0] !== 1'b0) begin
            n_err++; $display("FAIL gaps got dv=%b dout=%h perr=%b want dv=1 dout=3c perr=0", o_dv[0], o_dout[0], o_perr[0]); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (busy_bad[i] !== 0) begin n_err++; $display("FAIL busy[%0d] wrong_cycles=%0d want=0", i, busy_bad[i]); end
        end
    endtask

    task automatic test_abort();
        int ab0 = obs_ab[0];
        int dv0 = obs_dv[0];
        send_frame(8'hFF, 1'b0, 0, 1'b0, 0, 3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++; if (o_ab[0] !== 1'b1) begin n_err++; $display("FAIL abort_pulse got=%b want=1", o_ab[0]); end
        n_vec++; if (o_dout[0] !== 8'h3C) begin n_err++; $display("FAIL abort_dout_hold got=%h want=3c", o_dout[0]); end
        send_frame(8'h81, 1'b0, 2, 1'b0, 1, 8);
        n_vec++; if (o_dv[0] !== 1'b1 || o_dout[0] !== 8'h81 || o_perr[0] !== 1'b0) begin
            n_err++; $display("FAIL abort_new got dv=%b dout=%h perr=%b want dv=1 dout=81 perr=0", o_dv[0], o_dout[0], o_perr[0]); end
        n_vec++; if (obs_dv[0] - dv0 !== 1 || obs_ab[0] - ab0 !== 1) begin
            n_err++; $display("FAIL abort_counts got dv=%0d ab=%0d want dv=1 ab=1", obs_dv[0] - dv0, obs_ab[0] - ab0); end
    endtask

    task automatic test_err_sat();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (o_cnt[2] !== 8'd0) begin n_err++; $display("FAIL sat_clear got=%0d want=0", o_cnt[2]); end
        for (int n = 1; n <= 5; n++) begin
            send_frame(8'h01, 1'b0, 1, 1'b0, 0, 8);
            n_vec++; if (o_cnt[2] !== 8'((n > 3) ? 3 : n)) begin
                n_err++; $display("FAIL sat_cnt%0d got=%0d want=%0d", n, o_cnt[2], (n > 3) ? 3 : n); end
        end
        send_frame(8'h01, 1'b0, 1, 1'b1, 0, 8);
        n_vec++; if (o_cnt[2] !== 8'd0 || o_cnt[0] !== 8'd0) begin
            n_err++; $display("FAIL sat_clear_wins got=%0d/%0d want=0/0", o_cnt[2], o_cnt[0]); end
    endtask

    task automatic test_reset_midframe();
        int dv0, ab0;
        send_frame(8'hFF, 1'b0, 0, 1'b0, 0, 5);
        do_reset();
        dv0 = obs_dv[0]; ab0 = obs_ab[0];
        n_vec++; if (o_busy[0] !== 1'b0 || o_dout[0] !== 8'h00 || o_cnt[1] !== 8'd0) begin
            n_err++; $display("FAIL midreset got busy=%b dout=%h cnt=%0d want busy=0 dout=00 cnt=0", o_busy[0], o_dout[0], o_cnt[1]); end
        send_frame(8'hFF, 1'b0, 1, 1'b0, 0, 8);
        n_vec++; if (o_dv[0] !== 1'b1 || o_dout[0] !== 8'hFF || o_perr[0] !== 1'b0) begin
            n_err++; $display("FAIL after_reset got dv=%b dout=%h perr=%b want dv=1 dout=ff perr=0", o_dv[0], o_dout[0], o_perr[0]); end
        n_vec++; if (obs_dv[0] - dv0 !== 1 || obs_ab[0] - ab0 !== 0) begin
            n_err++; $display("FAIL after_reset_counts got dv=%0d ab=%0d want dv=1 ab=0", obs_dv[0] - dv0, obs_ab[0] - ab0); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0)
                send_frame(8'($urandom), 1'b0, 2, 1'b0, 0, int'($urandom_range(0, 7)));
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), 2, ($urandom_range(0, 5) == 0), 0, 8);
            for (int i = 0; i < 3; i++) begin
                n_vec++; if (o_dv[i] !== m_dv[i] || o_dout[i] !== m_dout[i] || o_perr[i] !== m_perr[i]
                             || o_cnt[i] !== 8'(m_cnt[i])) begin
                    n_err++; $display("FAIL rand%0d[%0d] got dv=%b dout=%h perr=%b cnt=%0d want dv=%b dout=%h perr=%b cnt=%0d",
                        f, i, o_dv[i], o_dout[i], o_perr[i], o_cnt[i], m_dv[i], m_dout[i], m_perr[i], m_cnt[i]); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (obs_dv[i] !== exp_dv[i] || obs_ab[i] !== exp_ab || busy_bad[i] !== 0) begin
                n_err++; $display("FAIL totals[%0d] got dv=%0d ab=%0d busybad=%0d want dv=%0d ab=%0d busybad=0",
                    i, obs_dv[i], obs_ab[i], busy_bad[i], exp_dv[i], exp_ab); end
        end
    endtask

    initial begin
        model_reset();
        exp_ab = 0;
        for (int i = 0; i < 3; i++) begin exp_dv[i] = 0; obs_dv[i] = 0; obs_ab[i] = 0; busy_bad[i] = 0; end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_even_good();
        test_bad_parity();
        test_gaps();
        test_abort();
        test_err_sat();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
